// File: rtl/config_write_scheduler.sv
// config_write_scheduler
// Queues register writes from the SPI port and releases them in one burst at
// the first sample-frame boundary after a host commit, so a parameter batch
// lands inside a single frame.
// Optional build macro: CFG_SINE_BYPASS_EN (sine-table writes skip the queue).
module config_write_scheduler #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_Clock,
    input  logic          i_Reset_n,
    input  logic          i_WriteEnable,
    input  logic [14:0]   i_WriteNumber,
    input  logic [15:0]   i_WriteValue,
    input  logic          i_Commit,
    input  logic          i_FrameStart,
    output logic          o_WriteEnable,
    output logic [14:0]   o_WriteNumber,
    output logic [15:0]   o_WriteValue,
    output logic          o_Busy,
    output logic          o_Overflow,
    output logic [AW:0]   o_Level
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_LVL = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [30:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [AW:0]   commit_count_q;
    logic [AW:0]   commit_count_d;
    state_t        state_q;

    logic          we_q;
    logic [14:0]   num_q;
    logic [15:0]   val_q;
    logic          busy_q;
    logic          ovf_q;

    logic          full_s;
    logic          bypass_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    assign full_s = (count_q == FULL_LVL);

`ifdef CFG_SINE_BYPASS_EN
    // Sine-table writes go straight to the output and steal the pop slot.
    assign bypass_s = i_WriteEnable & i_WriteNumber[14];
`else
    assign bypass_s = 1'b0;
`endif

    // commit_count never exceeds occupancy, so a nonzero count implies data.
    assign pop_s  = (state_q == ST_DRAIN) && (commit_count_q != ZERO_LVL) && !bypass_s;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_s = i_WriteEnable && !bypass_s && (!full_s || pop_s);
    assign drop_s = i_WriteEnable && !bypass_s && full_s && !pop_s;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_LVL;
            2'b01:   count_d = count_q - ONE_LVL;
            default: count_d = count_q;
        endcase
    end

    // Commit reloads the release count with post-push/pop occupancy; pops count it down.
    always_comb begin
        commit_count_d = commit_count_q;
        if (i_Commit && (count_d != ZERO_LVL)) begin
            commit_count_d = count_d;
        end else if (pop_s) begin
            commit_count_d = commit_count_q - ONE_LVL;
        end else begin
            commit_count_d = commit_count_q;
        end
    end

    // FIFO storage; entries need no reset because pointers gate every read.
    always_ff @(posedge i_Clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {i_WriteNumber, i_WriteValue};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= ZERO_LVL;
            ovf_q    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Release FSM with commit counter, busy flag and registered write port.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q        <= ST_IDLE;
            commit_count_q <= ZERO_LVL;
            busy_q         <= 1'b0;
            we_q           <= 1'b0;
            num_q          <= 15'd0;
            val_q          <= 16'd0;
        end else begin
            commit_count_q <= commit_count_d;

            case (state_q)
                ST_IDLE: begin
                    if (commit_count_q != ZERO_LVL) begin
                        state_q <= ST_ARMED;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    busy_q <= 1'b1;
                    if (i_FrameStart) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Frame pulses are ignored here; a recommit simply extends the drain.
                    if (commit_count_d == ZERO_LVL) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Data holds its last issued value when no strobe is issued.
            we_q <= bypass_s | pop_s;
            if (bypass_s) begin
                num_q <= i_WriteNumber;
                val_q <= i_WriteValue;
            end else if (pop_s) begin
                num_q <= mem_q[rd_ptr_q][30:16];
                val_q <= mem_q[rd_ptr_q][15:0];
            end
        end
    end

    assign o_WriteEnable = we_q;
    assign o_WriteNumber = num_q;
    assign o_WriteValue  = val_q;
    assign o_Busy        = busy_q;
    assign o_Overflow    = ovf_q;
    assign o_Level       = count_q;

endmodule

// File: tb/tb_config_write_scheduler.sv
// Scoreboard bench for config_write_scheduler: accepted writes are queued as
// expectations and compared, in order, against every output strobe.
module tb_config_write_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [14:0]   num = 15'd0;
    logic [15:0]   val = 16'd0;
    logic          cm = 1'b0;
    logic          fs = 1'b0;
    logic          o_we;
    logic [14:0]   o_num;
    logic [15:0]   o_val;
    logic          o_busy;
    logic          o_ovf;
    logic [AW:0]   o_level;

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            strobe_cnt = 0;
    int            first_cyc = -1;
    int            last_cyc = -1;
    int            frame_cyc = 0;
    int            snap;
    logic [30:0]   sb [$];
    logic [30:0]   exp_word;

    config_write_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_WriteEnable (we),
        .i_WriteNumber (num),
        .i_WriteValue  (val),
        .i_Commit      (cm),
        .i_FrameStart  (fs),
        .o_WriteEnable (o_we),
        .o_WriteNumber (o_num),
        .o_WriteValue  (o_val),
        .o_Busy        (o_busy),
        .o_Overflow    (o_ovf),
        .o_Level       (o_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && o_we) begin
            strobe_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 64'(sb.size()), 64'd1);
            end else begin
                exp_word = sb.pop_front();
                chk("strobe_data", 64'({o_num, o_val}), 64'(exp_word));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [14:0] n, input logic [15:0] v, input bit with_commit, input bit expect_out);
        we  = 1'b1;
        num = n;
        val = v;
        cm  = with_commit;
        if (expect_out) sb.push_back({n, v});
        tick(1);
        we = 1'b0;
        cm = 1'b0;
    endtask

    task automatic commit_pulse();
        cm = 1'b1;
        tick(1);
        cm = 1'b0;
    endtask

    task automatic frame_pulse();
        fs        = 1'b1;
        frame_cyc = cyc;
        first_cyc = -1;
        tick(1);
        fs = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(3);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_data", 64'({o_num, o_val}), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic batch of three voice-op writes
        strobe_cnt = 0;
        wr(15'h0105, 16'hAAAA, 1'b0, 1'b1);
        wr(15'h0206, 16'hBBBB, 1'b0, 1'b1);
        wr(15'h0307, 16'hCCCC, 1'b0, 1'b1);
        chk("basic_level", 64'(o_level), 64'd3);
        commit_pulse();
        tick(10);
        chk("basic_no_early", 64'(strobe_cnt), 64'd0);
        chk("basic_busy", 64'(o_busy), 64'd1);
        frame_pulse();
        tick(6);
        chk("basic_count", 64'(strobe_cnt), 64'd3);
        chk("basic_latency", 64'(first_cyc - frame_cyc), 64'd2);
        chk("basic_consec", 64'(last_cyc - first_cyc), 64'd2);
        chk("basic_level_end", 64'(o_level), 64'd0);
        chk("basic_idle", 64'(o_busy), 64'd0);

        // Overflow: 18 writes into 16 entries
        strobe_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            wr(15'h0100 + 15'(i), 16'h1000 + 16'(i), 1'b0, (i < DEPTH));
        end
        chk("ovf_level", 64'(o_level), 64'd16);
        chk("ovf_flag", 64'(o_ovf), 64'd1);
        commit_pulse();
        tick(3);
        frame_pulse();
        tick(22);
        chk("ovf_count", 64'(strobe_cnt), 64'd16);
        chk("ovf_level_end", 64'(o_level), 64'd0);

        // Writes after the commit wait for the next commit
        strobe_cnt = 0;
        wr(15'h0011, 16'h0001, 1'b0, 1'b1);
        wr(15'h0012, 16'h0002, 1'b0, 1'b1);
        commit_pulse();
        wr(15'h0013, 16'h0003, 1'b0, 1'b1);
        wr(15'h0014, 16'h0004, 1'b0, 1'b1);
        tick(2);
        frame_pulse();
        tick(8);
        chk("post_count1", 64'(strobe_cnt), 64'd2);
        chk("post_level", 64'(o_level), 64'd2);
        chk("post_idle", 64'(o_busy), 64'd0);
        commit_pulse();
        tick(3);
        frame_pulse();
        tick(8);
        chk("post_count2", 64'(strobe_cnt), 64'd4);
        chk("post_level_end", 64'(o_level), 64'd0);

        // Push and commit in the same cycle on an empty FIFO
        strobe_cnt = 0;
        wr(15'h0A0B, 16'h5A5A, 1'b1, 1'b1);
        tick(3);
        chk("same_busy", 64'(o_busy), 64'd1);
        frame_pulse();
        tick(6);
        chk("same_count", 64'(strobe_cnt), 64'd1);
        chk("same_latency", 64'(first_cyc - frame_cyc), 64'd2);

        // Commit alone on an empty FIFO is a no-op
        commit_pulse();
        for (int i = 0; i < 4; i++) begin
            chk("empty_commit_busy", 64'(o_busy), 64'd0);
            tick(1);
        end

`ifdef CFG_SINE_BYPASS_EN
        // Sine write during a drain bypasses the queue and slips the drain
        strobe_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            wr(15'h0200 + 15'(i), 16'h2000 + 16'(i), 1'b0, 1'b1);
        end
        commit_pulse();
        tick(3);
        frame_pulse();
        tick(1);
        we  = 1'b1;
        num = 15'h4010;
        val = 16'h1234;
        @(posedge clk);
        sb.push_front({15'h4010, 16'h1234});
        #1;
        we = 1'b0;
        tick(8);
        chk("byp_count", 64'(strobe_cnt), 64'd5);
        chk("byp_latency", 64'(first_cyc - frame_cyc), 64'd2);
        chk("byp_consec", 64'(last_cyc - first_cyc), 64'd4);
        chk("byp_level_end", 64'(o_level), 64'd0);
`else
        // Sine write is queued like any other
        strobe_cnt = 0;
        wr(15'h4010, 16'h1234, 1'b0, 1'b1);
        tick(2);
        chk("sine_level", 64'(o_level), 64'd1);
        chk("sine_held", 64'(strobe_cnt), 64'd0);
        commit_pulse();
        tick(3);
        frame_pulse();
        tick(6);
        chk("sine_count", 64'(strobe_cnt), 64'd1);
        chk("sine_level_end", 64'(o_level), 64'd0);
`endif

        // Reset in the middle of a drain with five entries left
        strobe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wr(15'h0300 + 15'(i), 16'h3000 + 16'(i), 1'b0, 1'b1);
        end
        commit_pulse();
        tick(3);
        frame_pulse();
        tick(3);
        chk("mid_strobes", 64'(strobe_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(o_we), 64'd0);
        chk("mid_rst_level", 64'(o_level), 64'd0);
        chk("mid_rst_ovf", 64'(o_ovf), 64'd0);
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        snap = strobe_cnt;
        tick(10);
        chk("mid_no_strobes", 64'(strobe_cnt), 64'(snap));
        chk("mid_level", 64'(o_level), 64'd0);
        chk("mid_busy", 64'(o_busy), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_write_scheduler.md
Name: config_write_scheduler

Overview:
Sits between the SPI register-write port and the voice-operator/sine-table config write enables of the synth pipeline. It queues incoming register writes in a FIFO and releases them only after a host commit, starting at a sample-frame boundary (voice-operator counter wrap). A batch of parameter changes therefore lands together inside one frame instead of straddling voices mid-frame.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..64
AW, 4, log2(DEPTH)

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  reset; asynchronous assert, active-low
i_WriteEnable  in  1  one-cycle write strobe (already rising-edge filtered)
i_WriteNumber  in  15  register number; bit14=1 sine table, bit14=0 voice-op (param[13:8], addr[7:0])
i_WriteValue  in  16  register data
i_Commit  in  1  one-cycle pulse: release all entries queued up to and including this cycle
i_FrameStart  in  1  one-cycle pulse when voice-operator counter == 0
o_WriteEnable  out  1  registered one-cycle write strobe to the datapath decode
o_WriteNumber  out  15  registered register number
o_WriteValue  out  16  registered data
o_Busy  out  1  1 in ARMED or DRAIN
o_Overflow  out  1  sticky: a write was dropped because the FIFO was full
o_Level  out  AW+1  FIFO occupancy

Behaviour:
- Reset (async, i_Reset_n=0): FIFO emptied; r_CommitCount=0; state IDLE; all outputs 0.
- Enqueue: i_WriteEnable and not full -> push {number,value}. When full -> drop the write and set o_Overflow; o_Level is unchanged.
- Commit: on i_Commit, r_CommitCount <= occupancy after this cycle's push/pop. A write arriving in the same cycle as the commit is included. A commit when that occupancy is 0 is a no-op.
- State IDLE: r_CommitCount>0 -> ARMED.
- State ARMED: wait for i_FrameStart; on the pulse -> DRAIN. A pulse arriving in the same cycle the state enters ARMED is not taken; wait for the next one.
- State DRAIN: pop one entry per cycle and decrement r_CommitCount. The output register drives o_WriteEnable=1 with the popped data on the following cycle, so the first output strobe comes 2 cycles after the i_FrameStart pulse. When r_CommitCount reaches 0 -> IDLE.
- Entries pushed after the commit stay queued and wait for the next commit.
- Simultaneous push and pop while full: both proceed and nothing is dropped.
- Recommit during ARMED or DRAIN: r_CommitCount is reloaded with the new occupancy, so the drain extends and no extra frame wait occurs.
- i_FrameStart during DRAIN: ignored.
- Outputs: o_WriteNumber/o_WriteValue hold the last issued value when o_WriteEnable=0.
- Pointers: AW-bit, wrapping modulo DEPTH. Occupancy is AW+1 bits.
- o_Level and o_Busy are registered.

Optional Feature:
CFG_SINE_BYPASS_EN
- Defined: a write with i_WriteNumber[14]=1 skips the FIFO and is issued on the next cycle regardless of state. If a DRAIN pop is due in that cycle, the pop stalls one cycle (bypass has priority); r_CommitCount and the FIFO are untouched.
- Undefined: sine-table writes are queued and committed like all others.

Test Plan:
- Reset mid-drain: assert i_Reset_n=0 during DRAIN with 5 entries left -> outputs 0 immediately; o_Level=0, o_Busy=0 after release; no further strobes.
- Basic batch: push 3 voice-op writes (0x0105/0xAAAA, 0x0206/0xBBBB, 0x0307/0xCCCC), commit, i_FrameStart 10 cycles later -> no o_WriteEnable before the frame pulse. o_WriteEnable high 3 consecutive cycles in FIFO order, first at FrameStart+2; then IDLE and o_Level=0.
- Overflow: DEPTH=16, push 18 writes without commit -> o_Level=16, o_Overflow=1. Commit + frame -> exactly 16 strobes carrying entries 0..15.
- Post-commit writes: push 2, commit, push 2 more, frame -> 2 strobes only; o_Level=2; second commit + frame -> remaining 2 strobes.
- Same-cycle commit and push with empty FIFO: push 1 write with i_Commit in the same cycle -> that write is issued after the next i_FrameStart. A commit alone on an empty FIFO -> o_Busy stays 0.
- Bypass (CFG_SINE_BYPASS_EN): during DRAIN of 4 entries, write 0x4010/0x1234 -> strobe with 0x4010 next cycle. The drain slips one cycle, all 4 queued writes still issue in order, and total strobes = 5.
